// File: rtl/uart_pkg.sv
// Shared definitions for the console UART path.
// Receiver state encoding and console ASCII constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic [7:0] ASC_0     = 8'd48;
    localparam logic [7:0] ASC_SPACE = 8'd32;
    localparam logic [7:0] ASC_CR    = 8'd13;
    localparam logic [7:0] ASC_LF    = 8'd10;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line plus falling-edge detect.
// Flops reset to 1 (idle level) so reset release never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            rx_s <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            rx_s <= meta;
            prev <= rx_s;
        end
    end

    assign rx_fall = prev & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with glitch rejection and framing-error pulse.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_byte_rx: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_t        state,     state_nxt;
    logic [CNT_W-1:0] clk_cnt,   cnt_nxt;
    logic [2:0]       bit_idx,   idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       data_nxt;
    logic             done_nxt;
    logic             ferr_nxt;

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_nxt;
    logic perr_q,  perr_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= cnt_nxt;
            bit_idx   <= idx_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= data_nxt;
            rx_done   <= done_nxt;
            frame_err <= ferr_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            par_bad <= par_bad_nxt;
            perr_q  <= perr_nxt;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = clk_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF) begin
                    cnt_nxt = '0;
                    idx_nxt = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == LAST) begin
                    shift_nxt[bit_idx] = rx_s;
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt == LAST) begin
                    par_bad_nxt = rx_s ^ (^shift_reg);
                    cnt_nxt     = '0;
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (clk_cnt == LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (!rx_s) begin
                        ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_nxt = 1'b1;
`endif
                    end else begin
                        data_nxt = shift_reg;
                        done_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed testbench for uart_byte_rx at 10 clocks per bit.
// Define UART_RX_PARITY_EN to also exercise 8E1 framing.
module tb_uart_byte_rx;
    import uart_pkg::*;

    localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PEXTRA = CPB;
`else
    localparam int PEXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_byte_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nd, nfe, npe, nmulti;
    int t_start, t_done;
    logic busy_q = 1'b0;
    logic [7:0] q[$];

    always @(posedge clk) cyc++;

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_done) begin
            nd++;
            q.push_back(rx_data);
            t_done = cyc;
        end
        if (frame_err) nfe++;
        if (parity_err) npe++;
        if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1)
            nmulti++;
        if (busy && !busy_q) t_start = cyc;
        busy_q = busy;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear();
        nd = 0;
        nfe = 0;
        npe = 0;
        q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic par,
                              input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < q.size()) ? {24'd0, q[i]} : 32'hFFFF;
    endfunction

    logic [7:0] seq [4];
    int bcnt;

    initial begin
        nd = 0; nfe = 0; npe = 0; nmulti = 0;
        t_start = 0; t_done = 0;
        tick(3);
        chk("rst_data", {24'd0, rx_data}, 32'h0);
        chk("rst_done", {31'd0, rx_done}, 32'h0);
        chk("rst_ferr", {31'd0, frame_err}, 32'h0);
        chk("rst_perr", {31'd0, parity_err}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // Single byte '5'
        clear();
        send(ASC_0 + 8'd5);
        tick(5);
        chk("b35_cnt", nd, 1);
        chk("b35_data", qat(0), 32'h35);
        chk("b35_lat", t_done - t_start, 95 + PEXTRA);
        chk("b35_busy", {31'd0, busy}, 32'h0);

        // Back-to-back "3 4\r"
        clear();
        seq[0] = ASC_0 + 8'd3;
        seq[1] = ASC_SPACE;
        seq[2] = ASC_0 + 8'd4;
        seq[3] = ASC_CR;
        for (int i = 0; i < 4; i++) send(seq[i]);
        tick(5);
        chk("b2b_cnt", nd, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("b2b_d%0d", i), qat(i), {24'd0, seq[i]});
        chk("b2b_ferr", nfe, 0);

        // 3-cycle glitch on idle line
        clear();
        bcnt = 0;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy) bcnt++;
        end
        chk("gl_done", nd, 0);
        chk("gl_ferr", nfe, 0);
        chk("gl_bsy_max", {31'd0, (bcnt >= 1 && bcnt <= 5)}, 32'h1);
        chk("gl_busy", {31'd0, busy}, 32'h0);

        // Framing error, line then held low
        clear();
        send_frame(8'h41, ^8'h41, 1'b0);
        rx = 1'b0;
        tick(30);
        chk("fe_busy", {31'd0, busy}, 32'h0);
        rx = 1'b1;
        tick(20);
        chk("fe_cnt", nfe, 1);
        chk("fe_done", nd, 0);
        chk("fe_data", {24'd0, rx_data}, {24'd0, ASC_CR});
        send(8'h42);
        tick(5);
        chk("fe_next", qat(0), 32'h42);

        // Reset during bit 4
        clear();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & ~(i == 1 || i == 3));
        rx = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("ar_data", {24'd0, rx_data}, 32'h0);
        chk("ar_busy", {31'd0, busy}, 32'h0);
        chk("ar_done", {31'd0, rx_done}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(CPB * 6);
        chk("ar_pulse", nd + nfe + npe, 0);
        send(ASC_0 + 8'd9);
        tick(5);
        chk("ar_next", qat(0), 32'h39);

`ifdef UART_RX_PARITY_EN
        clear();
        send_frame(8'h31, 1'b0, 1'b1);
        tick(5);
        chk("pe_cnt", npe, 1);
        chk("pe_done", nd, 0);
        chk("pe_data", {24'd0, rx_data}, 32'h39);
        clear();
        send_frame(8'h31, 1'b1, 1'b1);
        tick(5);
        chk("po_cnt", nd, 1);
        chk("po_data", qat(0), 32'h31);
        chk("po_perr", npe, 0);
`endif

        chk("excl", nmulti, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
